// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the arbiter FSM state type and the default geometry constants
// (word-index width, starvation counter width, starvation threshold).
package dmem_arb_pkg;

  localparam int unsigned DEF_AW           = 32'd6;
  localparam int unsigned DEF_CW           = 32'd4;
  localparam int unsigned DEF_STARVE_LIMIT = 32'd8;

  // IDLE: no DMA request held; WAIT: request latched, waiting for a CPU-free
  // cycle; RESP: access happened last cycle, completion pulse is shown.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter used to measure how long a DMA request has waited.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   inc         count one more waiting cycle (stops at all-ones)
//   clr         clear to zero (wins over inc)
//   cnt         current count
module sat_counter #(
  parameter int unsigned CW = 32'd4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, increment holds once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU (absolute priority, combinational
// pass-through) and a single-outstanding DMA port.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_we/re/addr/wdata/rdata  CPU access; cpu_addr is a byte address
//   dma_req/we/addr/wdata       DMA request, latched when accepted
//   dma_gnt                     latched DMA request drives dmem this cycle
//   dma_done                    one-cycle pulse the cycle after the grant
//   dma_rdata                   data captured by the last granted DMA read
//   mem_we/re/addr/wdata/rdata  dmem port (combinational read data)
//   starve_cnt, starved         denied-cycle count and threshold flag
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N            = 32'd64,
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned CW           = DEF_CW,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic [N-1:0]  cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [N-1:0]  dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [N-1:0]  dma_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic [CW-1:0] starve_cnt,
  output logic          starved
);

  localparam logic [CW:0] LIMIT_W = STARVE_LIMIT[CW:0];

  arb_state_e    state_q,     state_d;
  logic          req_we_q,    req_we_d;
  logic [AW-1:0] req_addr_q,  req_addr_d;
  logic [N-1:0]  req_wdata_q, req_wdata_d;
  logic [N-1:0]  rdata_q,     rdata_d;
  logic          done_q,      done_d;

  logic          cpu_act_s;
  logic          gnt_s;
  logic          starve_inc_s;
  logic [AW-1:0] cpu_idx_s;
  logic          unused_addr_bits_s;

  assign cpu_act_s          = cpu_we | cpu_re;
  assign cpu_idx_s          = cpu_addr[AW+2:3];
  assign unused_addr_bits_s = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

  // A held request only reaches dmem on a cycle the CPU leaves free.
  assign gnt_s        = (state_q == WAIT) && !cpu_act_s;
  assign starve_inc_s = (state_q == WAIT) && cpu_act_s;

  // dmem port mux; the enables are gated by reset so a CPU access during
  // reset still shows address/data but never strobes the memory.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {N{1'b0}};
    if (cpu_act_s) begin
      mem_we    = cpu_we & reset;
      mem_re    = cpu_re & reset;
      mem_addr  = cpu_idx_s;
      mem_wdata = cpu_wdata;
    end else if (gnt_s) begin
      mem_we    = req_we_q;
      mem_re    = ~req_we_q;
      mem_addr  = req_addr_q;
      mem_wdata = req_wdata_q;
    end else begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {N{1'b0}};
    end
  end

  // FSM next state, request latch and DMA read capture.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        // A new request can be taken both from IDLE and straight out of RESP.
        if (dma_req) begin
          req_we_d    = dma_we;
          req_addr_d  = dma_addr;
          req_wdata_d = dma_wdata;
          state_d     = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (gnt_s) begin
          state_d = RESP;
          done_d  = 1'b1;
          if (!req_we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch, captured read data and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= {AW{1'b0}};
      req_wdata_q <= {N{1'b0}};
      rdata_q     <= {N{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
    end
  end

  sat_counter #(
    .CW(CW)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (starve_inc_s),
    .clr  (gnt_s),
    .cnt  (starve_cnt)
  );

  assign starved   = ({1'b0, starve_cnt} >= LIMIT_W);
  assign dma_gnt   = gnt_s;
  assign dma_done  = done_q;
  assign dma_rdata = rdata_q;
  assign cpu_rdata = mem_rdata;

endmodule
